// File: rtl/ram_pkg.sv
// Shared types and widths for the parameterised RAM slave.
package ram_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } ram_state_e;

    // Request payload captured at acceptance.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } ram_req_t;

endpackage

// File: rtl/ram_param_if.sv
// Valid/ready memory bus between a master and the RAM slave.
interface ram_param_if;
    import ram_pkg::*;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_err;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, mem_err
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, mem_err
    );

endinterface

// File: rtl/ram_array.sv
// DEPTH x 32 storage with per-byte write enable and a synchronous
// read-before-write port; clr_i zeroes the read register.
module ram_array
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       clr_i,
    input  logic [STRB_W-1:0]          wstrb_i,
    input  logic [$clog2(DEPTH)-1:0]   addr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is never reset; callers gate en_i during reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_param.sv
// Valid/ready RAM slave with configurable depth, base address and wait states.
// Define RAM_OUTREG_EN to add a registered RESP stage on read data and error.
module ram_param
    import ram_pkg::*;
#(
    parameter int unsigned       DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned       WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    ram_param_if.slave  bus
);

    localparam int unsigned       AW        = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(4 * DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    ram_state_e        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    ram_req_t          req_q, req_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    ram_req_t          acc_req_c;
    logic [ADDR_W-1:0] acc_off_c;
    logic              acc_hit_c;
    logic              access_c;
    logic [DATA_W-1:0] arr_rdata;

    // Request seen by the array: live inputs when accepting from IDLE, else latched.
    always_comb begin
        acc_req_c = req_q;
        if (state_q == IDLE) begin
            acc_req_c.addr  = bus.mem_addr;
            acc_req_c.wdata = bus.mem_wdata;
            acc_req_c.wstrb = bus.mem_wstrb;
        end
    end

    // Unsigned offset: addresses below BASE_ADDR become huge and fail the compare.
    assign acc_off_c = acc_req_c.addr - BASE_ADDR;
    assign acc_hit_c = (acc_off_c < SPAN);
    assign access_c  = (state_d == ACCESS) && (state_q != ACCESS);

    ram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .en_i    (access_c && acc_hit_c && !rst),
        .clr_i   (access_c && !acc_hit_c),
        .wstrb_i (acc_req_c.wstrb),
        .addr_i  (acc_off_c[AW+1:2]),
        .wdata_i (acc_req_c.wdata),
        .rdata_o (arr_rdata)
    );

`ifdef RAM_OUTREG_EN
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
`ifdef RAM_OUTREG_EN
        oor_d   = oor_q;
        rdata_d = rdata_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    req_d   = acc_req_c;
                    cnt_d   = '0;
                    state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + WAIT_W'(1);
                if (!bus.mem_valid) begin
                    state_d = IDLE;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = ACCESS;
                end
            end
`ifdef RAM_OUTREG_EN
            ACCESS:  state_d = RESP;
`else
            ACCESS:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

`ifdef RAM_OUTREG_EN
        if (access_c) begin
            oor_d = !acc_hit_c;
        end
        if (state_q == ACCESS) begin
            ready_d = 1'b1;
            err_d   = oor_q;
            rdata_d = arr_rdata;
        end
`else
        ready_d = access_c;
        err_d   = access_c && !acc_hit_c;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef RAM_OUTREG_EN
            oor_q   <= 1'b0;
            rdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            err_q   <= err_d;
`ifdef RAM_OUTREG_EN
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
`endif
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;
`ifdef RAM_OUTREG_EN
    assign bus.mem_rdata = rdata_q;
`else
    assign bus.mem_rdata = arr_rdata;
`endif

endmodule

// File: tb/tb_ram_param.sv
// Directed bench for ram_param: three instances covering WAIT_STATES 0/3/5,
// a relocated 16-word array, aborts and reset during WAIT.
module tb_ram_param;

`ifdef RAM_OUTREG_EN
    localparam int OUT = 1;
`else
    localparam int OUT = 0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v;
    logic [2:0]  valid_v;
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic [3:0]  wstrb_v [3];
    logic [2:0]  ready_w;
    logic [2:0]  err_w;
    logic [31:0] rdata_w [3];

    int n_checks = 0;
    int n_fail   = 0;

    ram_param_if bus_a ();
    ram_param_if bus_b ();
    ram_param_if bus_c ();

    assign bus_a.mem_valid = valid_v[0];
    assign bus_a.mem_addr  = addr_v[0];
    assign bus_a.mem_wdata = wdata_v[0];
    assign bus_a.mem_wstrb = wstrb_v[0];
    assign ready_w[0]      = bus_a.mem_ready;
    assign err_w[0]        = bus_a.mem_err;
    assign rdata_w[0]      = bus_a.mem_rdata;

    assign bus_b.mem_valid = valid_v[1];
    assign bus_b.mem_addr  = addr_v[1];
    assign bus_b.mem_wdata = wdata_v[1];
    assign bus_b.mem_wstrb = wstrb_v[1];
    assign ready_w[1]      = bus_b.mem_ready;
    assign err_w[1]        = bus_b.mem_err;
    assign rdata_w[1]      = bus_b.mem_rdata;

    assign bus_c.mem_valid = valid_v[2];
    assign bus_c.mem_addr  = addr_v[2];
    assign bus_c.mem_wdata = wdata_v[2];
    assign bus_c.mem_wstrb = wstrb_v[2];
    assign ready_w[2]      = bus_c.mem_ready;
    assign err_w[2]        = bus_c.mem_err;
    assign rdata_w[2]      = bus_c.mem_rdata;

    ram_param #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0))
        u_dut_a (.clk(clk), .rst(rst_v[0]), .bus(bus_a));
    ram_param #(.DEPTH(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3))
        u_dut_b (.clk(clk), .rst(rst_v[1]), .bus(bus_b));
    ram_param #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(5))
        u_dut_c (.clk(clk), .rst(rst_v[2]), .bus(bus_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request at a negedge with the DUT idle; scramble inputs after acceptance.
    task automatic req(input int d, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd,
                       output logic er, output int lat);
        valid_v[d] = 1'b1;
        addr_v[d]  = a;
        wdata_v[d] = wd;
        wstrb_v[d] = st;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        @(posedge clk);
        #1;
        addr_v[d]  = ~a;
        wdata_v[d] = ~wd;
        wstrb_v[d] = ~st;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ready_w[d]) begin
                lat = i;
                rd  = rdata_w[d];
                er  = err_w[d];
                break;
            end
        end
        valid_v[d] = 1'b0;
        wstrb_v[d] = 4'h0;
        @(negedge clk);
    endtask

    task automatic xfer(input string tag, input int d, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input bit chk_rd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        req(d, a, wd, st, rd, er, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        if (chk_rd) chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_ready_once"}, {31'd0, ready_w[d]}, 32'd0);
        chk({tag, "_err_idle"}, {31'd0, err_w[d]}, 32'd0);
    endtask

    task automatic watch(input int d, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ready_w[d]) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int first;
        int second;
        rst_v   = 3'b111;
        valid_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_v[i]  = '0;
            wdata_v[i] = '0;
            wstrb_v[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst_v = 3'b000;
        @(negedge clk);

        chk("rst_rdata_a", rdata_w[0], 32'h0);
        chk("rst_ready_a", {31'd0, ready_w[0]}, 32'h0);
        chk("rst_err_a",   {31'd0, err_w[0]}, 32'h0);
        chk("rst_ready_b", {31'd0, ready_w[1]}, 32'h0);

        // Instance A: zero wait states, base 0, 1024 words.
        xfer("a_wr10",   0, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0, 1 + OUT);
        xfer("a_rd10",   0, 32'h10,  32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1 + OUT);
        xfer("a_wr10p",  0, 32'h10,  32'h00AA0055, 4'h5, 1'b1, 32'hDEADBEEF, 1'b0, 1 + OUT);
        xfer("a_rd10p",  0, 32'h10,  32'h0,        4'h0, 1'b1, 32'hDEAABE55, 1'b0, 1 + OUT);
        chk("a_rdata_hold", rdata_w[0], 32'hDEAABE55);
        xfer("a_rd13",   0, 32'h13,  32'h0,        4'h0, 1'b1, 32'hDEAABE55, 1'b0, 1 + OUT);
        xfer("a_wr0",    0, 32'h0,   32'h11111111, 4'hF, 1'b0, 32'h0,        1'b0, 1 + OUT);
        xfer("a_wrlast", 0, 32'hFFC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0, 1 + OUT);
        xfer("a_oor_hi", 0, 32'h1000, 32'h12345678, 4'hF, 1'b1, 32'h0,       1'b1, 1 + OUT);
        chk("a_oor_hold", rdata_w[0], 32'h0);
        xfer("a_oor_top", 0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b1, 32'h0,        1'b1, 1 + OUT);
        xfer("a_rd0",    0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h11111111, 1'b0, 1 + OUT);
        xfer("a_rdlast", 0, 32'hFFC, 32'h0,        4'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1 + OUT);

        // Instance B: three wait states, 16 words at 0x1000.
        xfer("b_wr0",    1, 32'h1000, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0,       1'b0, 4 + OUT);
        xfer("b_wrl",    1, 32'h103C, 32'h5A5A5A5A, 4'hF, 1'b0, 32'h0,       1'b0, 4 + OUT);
        xfer("b_oor_hi", 1, 32'h1040, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,       1'b1, 4 + OUT);
        xfer("b_oor_lo", 1, 32'h0FFC, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,       1'b1, 4 + OUT);
        xfer("b_rd0",    1, 32'h1000, 32'h0,        4'h0, 1'b1, 32'hA5A5A5A5, 1'b0, 4 + OUT);
        xfer("b_rdl",    1, 32'h103C, 32'h0,        4'h0, 1'b1, 32'h5A5A5A5A, 1'b0, 4 + OUT);

        // Valid held high: ready at +4, one idle cycle, re-accept, ready again.
        valid_v[1] = 1'b1;
        addr_v[1]  = 32'h1000;
        wstrb_v[1] = 4'h0;
        cnt = 0;
        first = 0;
        second = 0;
        for (int i = 1; i <= 9 + 2 * OUT; i++) begin
            @(negedge clk);
            if (ready_w[1]) begin
                cnt++;
                if (cnt == 1) first = i;
                else if (cnt == 2) second = i;
            end
        end
        valid_v[1] = 1'b0;
        chk("b_hold_count",  32'(cnt),    32'd2);
        chk("b_hold_first",  32'(first),  32'(4 + OUT));
        chk("b_hold_second", 32'(second), 32'(9 + 2 * OUT));
        @(negedge clk);

        // Abort mid-WAIT: no completion, no write.
        valid_v[1] = 1'b1;
        addr_v[1]  = 32'h1000;
        wdata_v[1] = 32'h0;
        wstrb_v[1] = 4'hF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        valid_v[1] = 1'b0;
        wstrb_v[1] = 4'h0;
        watch(1, 10, cnt);
        chk("b_abort_ready", 32'(cnt), 32'd0);
        xfer("b_abort_rd", 1, 32'h1000, 32'h0, 4'h0, 1'b1, 32'hA5A5A5A5, 1'b0, 4 + OUT);

        // Instance C: reset pulsed in WAIT cancels the write.
        xfer("c_wr", 2, 32'h20, 32'h13579BDF, 4'hF, 1'b0, 32'h0, 1'b0, 6 + OUT);
        valid_v[2] = 1'b1;
        addr_v[2]  = 32'h20;
        wdata_v[2] = 32'h2468ACE0;
        wstrb_v[2] = 4'hF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_v[2]   = 1'b1;
        valid_v[2] = 1'b0;
        wstrb_v[2] = 4'h0;
        @(negedge clk);
        rst_v[2]   = 1'b0;
        chk("c_rst_rdata", rdata_w[2], 32'h0);
        watch(2, 12, cnt);
        chk("c_rst_ready", 32'(cnt), 32'd0);
        xfer("c_rd", 2, 32'h20, 32'h0, 4'h0, 1'b1, 32'h13579BDF, 1'b0, 6 + OUT);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: number of 32-bit words; power of two, 16..65536.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH.
REQ-003 SHALL have parameter WAIT_STATES, default 0: extra wait cycles per access, 0..15.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port mem_valid, input, 1: request present; held by the master until mem_ready.
REQ-007 SHALL have port mem_ready, output, 1: one-cycle completion pulse.
REQ-008 SHALL have port mem_addr, input, 32: byte address; bits [1:0] ignored.
REQ-009 SHALL have port mem_rdata, output, 32: read data, valid in the mem_ready cycle.
REQ-010 SHALL have port mem_wdata, input, 32: write data.
REQ-011 SHALL have port mem_wstrb, input, 4: byte write enables; 4'b0000 means read.
REQ-012 SHALL have port mem_err, output, 1: out-of-range flag, valid in the mem_ready cycle.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACCESS, and RESP (RESP only with RAM_OUTREG_EN).
- IDLE -> WAIT on mem_valid when WAIT_STATES>0.
- IDLE -> ACCESS on mem_valid when WAIT_STATES=0.
- WAIT -> ACCESS when the wait counter reaches WAIT_STATES.
- ACCESS -> IDLE, or ACCESS -> RESP when RAM_OUTREG_EN is defined.
- RESP -> IDLE.
REQ-014 SHALL load a 4-bit wait counter with 0 on acceptance and increment it once per WAIT cycle.
REQ-015 SHALL latch addr/wdata/wstrb at acceptance; later input changes SHALL NOT affect the transaction.
REQ-016 SHALL index storage with word index (mem_addr - BASE_ADDR) >> 2.
REQ-017 SHALL perform read and byte-masked write in the ACCESS cycle; read SHALL return pre-write data (read-before-write).
REQ-018 SHALL write only the bytes whose mem_wstrb bit is set and leave the other bytes unchanged.
REQ-019 SHALL assert mem_ready for exactly one cycle, at the transaction's final state (ACCESS, or RESP with RAM_OUTREG_EN).
REQ-020 SHALL give latency from acceptance edge to mem_ready of 1+WAIT_STATES cycles, +1 with RAM_OUTREG_EN.
REQ-021 SHALL return to IDLE in the cycle after mem_ready and SHALL NOT accept in that cycle, even if mem_valid is still high; minimum request spacing is 2 cycles.
REQ-022 SHALL handle an out-of-range address (outside BASE_ADDR..BASE_ADDR+4*DEPTH-1) as follows: no write, mem_rdata=0, mem_err=1 with mem_ready, same latency.
REQ-023 SHALL drive mem_err=0 outside the mem_ready cycle.
REQ-024 SHALL hold mem_rdata until the next completion.
REQ-025 SHALL abort to IDLE if mem_valid drops before ACCESS: no write, no mem_ready.
REQ-026 SHALL ignore mem_valid changes once ACCESS has been entered.
REQ-027 SHALL treat address arithmetic as 32-bit unsigned; addresses below BASE_ADDR SHALL NOT wrap into range.

Reset
REQ-028 SHALL, on rst, set the FSM to IDLE and clear the wait counter, mem_ready, mem_err, and mem_rdata to 0 on the same edge.
REQ-029 SHALL NOT clear or alter storage contents on rst.
REQ-030 SHALL cancel an in-flight transaction on rst asserted before ACCESS: no write, no mem_ready.
REQ-031 SHALL leave a write committed in ACCESS in place when rst is asserted in RESP, with mem_ready suppressed.

Configuration
REQ-032 SHALL, when RAM_OUTREG_EN is defined, register read data and mem_err through a RESP stage, adding 1 cycle of latency.
REQ-033 SHALL, when RAM_OUTREG_EN is undefined, drive mem_rdata directly from the array's read register in the ACCESS cycle and omit the RESP state.

Structure
REQ-034 SHALL take the FSM state enum, DATA_W=32, STRB_W=4 and WAIT_W=4 from shared package ram_pkg.
REQ-035 SHALL place storage in sub-module ram_array (DEPTH x 32, per-byte write enable, synchronous read-before-write port), containing no handshake logic.

Verification
REQ-036 SHALL cover: WAIT_STATES=0, no OUTREG; write 0xDEADBEEF strb 4'hF to 0x10, then read 0x10 -> mem_ready 1 cycle after acceptance, rdata 0xDEADBEEF, err 0.
REQ-037 SHALL cover: word 0x10 = 0xDEADBEEF, write 0x00AA0055 strb 4'b0101 -> read returns 0xDEAA BE55; the write's own rdata is 0xDEADBEEF.
REQ-038 SHALL cover: WAIT_STATES=3, mem_valid held continuously -> mem_ready at acceptance+4, then one idle cycle, then re-acceptance; with RAM_OUTREG_EN, mem_ready at +5.
REQ-039 SHALL cover: BASE_ADDR=0x1000, DEPTH=16, write to 0x1040 and to 0x0FFC -> both return mem_err=1, rdata 0, and the array is unchanged.
REQ-040 SHALL cover: WAIT_STATES=5, rst pulsed in the WAIT state during a write -> no mem_ready, target word unchanged, next request completes normally.
REQ-041 SHALL cover: mem_valid dropped mid-WAIT -> FSM returns to IDLE, no write, no mem_ready.
